// File: rtl/psg_pkg.sv
// Shared PSG constants: channel count, field widths and the attenuation-to-volume table.
package psg_pkg;

  localparam int unsigned NUM_TONE_CH = 3;
  localparam int unsigned PERIOD_W    = 10;
  localparam int unsigned ATTEN_W     = 4;
  localparam int unsigned VOL_W       = 8;
  localparam int unsigned AUDIO_W     = 10;

  // Entry [15] first; code 0 is loudest, code 15 is silent.
  localparam logic [15:0][VOL_W-1:0] VOL_TABLE = {
    8'd0,   8'd10,  8'd13,  8'd16,  8'd20,  8'd26,  8'd32,  8'd40,
    8'd51,  8'd64,  8'd81,  8'd102, 8'd128, 8'd161, 8'd203, 8'd255
  };

  function automatic logic [VOL_W-1:0] vol_lookup(input logic [ATTEN_W-1:0] code);
    return VOL_TABLE[code];
  endfunction

endpackage

// File: rtl/psg_tone_channel.sv
// One square-wave tone channel: period/attenuation registers, tick-driven
// down-counter with toggle flop, effective level and volume contribution.
module psg_tone_channel
  import psg_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                load_period,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                load_atten,
  input  logic [ATTEN_W-1:0]  atten_in,
  output logic                level,
  output logic [VOL_W-1:0]    vol
);

  logic [PERIOD_W-1:0] period;
  logic [ATTEN_W-1:0]  atten;
  logic [PERIOD_W-1:0] counter;
  logic                flop;

  // Writes never disturb the counter; a reload on the write cycle sees the old period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period  <= '0;
      atten   <= '1;
      counter <= '0;
      flop    <= 1'b0;
    end else begin
      if (load_period) period <= period_in;
      if (load_atten)  atten  <= atten_in;
      if (tick) begin
        if (counter <= PERIOD_W'(1)) begin
          counter <= period;
          flop    <= ~flop;
        end else begin
          counter <= counter - PERIOD_W'(1);
        end
      end
    end
  end

  // Periods 0 and 1 hold the output at DC high.
  assign level = (period < PERIOD_W'(2)) ? 1'b1 : flop;
  assign vol   = level ? vol_lookup(atten) : '0;

endmodule

// File: rtl/psg_tone_bank.sv
// Three-channel PSG tone bank: shared tick prescaler, per-channel generators,
// and a registered mixer producing one audio sample per tick.
module psg_tone_bank
  import psg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_TONE_CH-1:0] enable,
  input  logic [PERIOD_W-1:0]    freq,
  input  logic [NUM_TONE_CH-1:0] atten_enable,
  input  logic [ATTEN_W-1:0]     atten_mag,
  output logic [NUM_TONE_CH-1:0] tone_out,
  output logic [AUDIO_W-1:0]     audio,
  output logic                   sample_valid
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0]   prescaler;
  logic               tick;
  logic [VOL_W-1:0]   vol [NUM_TONE_CH];
  logic [AUDIO_W-1:0] mix_sum;

  assign tick = (prescaler == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_TONE_CH; i++) begin : g_ch
    psg_tone_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .load_period (enable[i]),
      .period_in   (freq),
      .load_atten  (atten_enable[i]),
      .atten_in    (atten_mag),
      .level       (tone_out[i]),
      .vol         (vol[i])
    );
  end

  // Three 8-bit contributions peak at 765, so 10 bits never overflow.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_TONE_CH; i++) begin
      mix_sum = mix_sum + AUDIO_W'(vol[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick;
      if (tick) audio <= mix_sum;
    end
  end

endmodule

// File: tb/tb_psg_tone_bank.sv
// Randomized and directed bench for psg_tone_bank against a tick-level reference model.
module tb_psg_tone_bank;

  localparam int CLK_DIV = 16;

  logic       clk;
  logic       reset;
  logic [2:0] enable;
  logic [9:0] freq;
  logic [2:0] atten_enable;
  logic [3:0] atten_mag;
  logic [2:0] tone_out;
  logic [9:0] audio;
  logic       sample_valid;

  psg_tone_bank #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .freq         (freq),
    .atten_enable (atten_enable),
    .atten_mag    (atten_mag),
    .tone_out     (tone_out),
    .audio        (audio),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: spec-level state held as plain integers.
  int vol_tab [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};
  int m_per [3];
  int m_att [3];
  int m_cnt [3];
  int m_flop [3];
  int m_pre, m_audio, m_sv;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_per[i] = 0; m_att[i] = 15; m_cnt[i] = 0; m_flop[i] = 0;
    end
    m_pre = 0; m_audio = 0; m_sv = 0;
  endfunction

  function automatic int model_level(input int i);
    return (m_per[i] < 2) ? 1 : m_flop[i];
  endfunction

  function automatic int model_tone();
    return model_level(0) + 2 * model_level(1) + 4 * model_level(2);
  endfunction

  function automatic void model_clock(input logic [2:0] en, input int fr,
                                      input logic [2:0] aen, input int am);
    int sum;
    bit is_tick;
    is_tick = (m_pre == CLK_DIV - 1);
    m_sv = is_tick ? 1 : 0;
    if (is_tick) begin
      sum = 0;
      for (int i = 0; i < 3; i++) if (model_level(i) == 1) sum += vol_tab[m_att[i]];
      m_audio = sum;
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] <= 1) begin
          m_cnt[i] = m_per[i];
          m_flop[i] = 1 - m_flop[i];
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    m_pre = is_tick ? 0 : m_pre + 1;
    for (int i = 0; i < 3; i++) begin
      if (en[i])  m_per[i] = fr;
      if (aen[i]) m_att[i] = am;
    end
  endfunction

  task automatic compare();
    chk("tone_out", int'(tone_out), model_tone());
    chk("audio", int'(audio), m_audio);
    chk("sample_valid", int'(sample_valid), m_sv);
  endtask

  // Called at a negedge: drive inputs, advance one clock, check at the following negedge.
  task automatic step(input logic [2:0] en, input logic [9:0] fr,
                      input logic [2:0] aen, input logic [3:0] am);
    enable = en; freq = fr; atten_enable = aen; atten_mag = am;
    @(posedge clk);
    model_clock(en, int'(fr), aen, int'(am));
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b000, 10'd0, 3'b000, 4'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int first_sv, sv_count, max_audio;

  initial begin
    reset = 1'b1;
    enable = '0; freq = '0; atten_enable = '0; atten_mag = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_tone", int'(tone_out), 7);
    chk("reset_audio", int'(audio), 0);
    chk("reset_sv", int'(sample_valid), 0);
    reset = 1'b0;

    // Idle after reset: sample pulses every CLK_DIV clocks, silent audio.
    first_sv = -1; sv_count = 0;
    for (int n = 1; n <= 200; n++) begin
      step(3'b000, 10'd0, 3'b000, 4'd0);
      if (sample_valid) begin
        sv_count++;
        if (first_sv < 0) first_sv = n;
      end
    end
    chk("first_sv_edge", first_sv, CLK_DIV);
    chk("sv_count_200", sv_count, 200 / CLK_DIV);

    // Single loud channel at period 4.
    step(3'b001, 10'd4, 3'b001, 4'd0);
    max_audio = 0;
    for (int n = 0; n < 300; n++) begin
      step(3'b000, 10'd0, 3'b000, 4'd0);
      if (int'(audio) > max_audio) max_audio = int'(audio);
    end
    chk("ch0_peak", max_audio, 255);

    // All three in phase, then drop ch1 to attenuation 2.
    do_reset();
    step(3'b111, 10'd4, 3'b111, 4'd0);
    max_audio = 0;
    for (int n = 0; n < 100; n++) begin
      step(3'b000, 10'd0, 3'b000, 4'd0);
      if (int'(audio) > max_audio) max_audio = int'(audio);
    end
    chk("in_phase_peak", max_audio, 765);
    step(3'b000, 10'd0, 3'b010, 4'd2);
    idle(CLK_DIV);
    max_audio = 0;
    for (int n = 0; n < 100; n++) begin
      step(3'b000, 10'd0, 3'b000, 4'd0);
      if (int'(audio) > max_audio) max_audio = int'(audio);
    end
    chk("atten2_peak", max_audio, 671);

    // Randomized writes, including mid-count period changes.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] en, aen;
      logic [9:0] fr;
      logic [3:0] am;
      en  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      aen = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      fr  = 10'($urandom_range(0, 12));
      am  = 4'($urandom_range(0, 15));
      step(en, fr, aen, am);
    end

    // DC channel, then asynchronous reset mid-tone.
    do_reset();
    step(3'b100, 10'd1, 3'b100, 4'd0);
    idle(40);
    chk("dc_tone2", int'(tone_out[2]), 1);
    chk("dc_audio", int'(audio), 255);
    #2 reset = 1'b1;
    #1;
    chk("async_audio", int'(audio), 0);
    chk("async_sv", int'(sample_valid), 0);
    chk("async_tone", int'(tone_out), 7);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    first_sv = -1;
    for (int n = 1; n <= 40; n++) begin
      step(3'b000, 10'd0, 3'b000, 4'd0);
      if (sample_valid && first_sv < 0) first_sv = n;
    end
    chk("post_reset_first_sv", first_sv, CLK_DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
